multicycle_controller: RTL and testbench

//  Control FSM that sequences the RISC-V multi-cycle datapath through the phases FETCH -> DECODE -> EXEC -> [MEM] -> WB.

---
 rtl/multicycle_controller_if.sv | 40 ++++
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 tb/tb_multicycle_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - decoder/memory handshake and status bundle for the multi-cycle controller
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       in_opcode;
   logic             in_reg_write;
   logic             in_mem_write;
   logic             in_ebreak;
   logic             in_imem_ready;
   logic             in_dmem_ready;
   logic             in_resume;
   logic             out_imem_req;
   logic             out_ir_write;
   logic             out_dmem_req;
   logic             out_dmem_we;
   logic             out_rf_write;
   logic             out_pc_write;
   logic             out_halted;
   logic             out_fault;
   logic [1:0]       out_fault_code;
   logic [2:0]       out_state;
   logic [CNT_W-1:0] out_instret;
   logic [CNT_W-1:0] out_cycles;

   modport master (
      input  in_opcode, in_reg_write, in_mem_write, in_ebreak,
             in_imem_ready, in_dmem_ready, in_resume,
      output out_imem_req, out_ir_write, out_dmem_req, out_dmem_we,
             out_rf_write, out_pc_write, out_halted, out_fault,
             out_fault_code, out_state, out_instret, out_cycles
   );

   modport slave (
      output in_opcode, in_reg_write, in_mem_write, in_ebreak,
             in_imem_ready, in_dmem_ready, in_resume,
      input  out_imem_req, out_ir_write, out_dmem_req, out_dmem_we,
             out_rf_write, out_pc_write, out_halted, out_fault,
             out_fault_code, out_state, out_instret, out_cycles
   );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with halt, fault, timeout and counters
module multicycle_controller #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_controller_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_ENV  = 7'b1110011;
   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t            state_q;
   logic [1:0]        fault_code_q;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  instret_q;
   logic [CNT_W-1:0]  cycles_q;

   logic legal;
   logic is_load;
   logic timeout_hit;
   logic retire;

   always_comb begin
      legal = 1'b0;
      case (bus.in_opcode)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   assign is_load     = (bus.in_opcode == OP_LOAD);
   assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

   // Strobes are a function of the current state and the live handshakes.
   always_comb begin
      bus.out_imem_req = 1'b0;
      bus.out_ir_write = 1'b0;
      bus.out_dmem_req = 1'b0;
      bus.out_dmem_we  = 1'b0;
      bus.out_rf_write = 1'b0;
      bus.out_pc_write = 1'b0;
      retire           = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.out_imem_req = 1'b1;
            bus.out_ir_write = bus.in_imem_ready;
         end
         S_MEM: begin
            bus.out_dmem_req = 1'b1;
            bus.out_dmem_we  = bus.in_mem_write;
            bus.out_pc_write = bus.in_dmem_ready & bus.in_mem_write;
            retire           = bus.in_dmem_ready & bus.in_mem_write;
         end
         S_WB: begin
            bus.out_rf_write = bus.in_reg_write;
            bus.out_pc_write = 1'b1;
            retire           = 1'b1;
         end
         S_HALT: begin
            bus.out_pc_write = bus.in_resume;
            retire           = bus.in_resume;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         fault_code_q <= 2'd0;
         wait_q       <= '0;
         instret_q    <= '0;
         cycles_q     <= '0;
      end else begin
         if (state_q != S_HALT && state_q != S_FAULT) cycles_q <= cycles_q + CNT_W'(1);
         if (retire) instret_q <= instret_q + CNT_W'(1);
         case (state_q)
            S_FETCH: begin
               if (bus.in_imem_ready) begin
                  state_q <= S_DECODE;
               end else if (timeout_hit) begin
                  state_q      <= S_FAULT;
                  fault_code_q <= 2'd2;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               if (bus.in_opcode == OP_ENV) begin
                  state_q <= S_HALT;
               end else if (!legal) begin
                  state_q      <= S_FAULT;
                  fault_code_q <= 2'd1;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_load || bus.in_mem_write) begin
                  state_q <= S_MEM;
                  wait_q  <= '0;
               end else begin
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (bus.in_dmem_ready) begin
                  state_q <= bus.in_mem_write ? S_FETCH : S_WB;
                  wait_q  <= '0;
               end else if (timeout_hit) begin
                  state_q      <= S_FAULT;
                  fault_code_q <= 2'd3;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            S_WB: begin
               state_q <= S_FETCH;
               wait_q  <= '0;
            end
            S_HALT: begin
               if (bus.in_resume) begin
                  state_q <= S_FETCH;
                  wait_q  <= '0;
               end
            end
            default: state_q <= S_FAULT;
         endcase
      end
   end

   assign bus.out_state      = state_q;
   assign bus.out_halted     = (state_q == S_HALT);
   assign bus.out_fault      = (state_q == S_FAULT);
   assign bus.out_fault_code = fault_code_q;
   assign bus.out_instret    = instret_q;
   assign bus.out_cycles     = cycles_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed checks of the multi-cycle controller sequencing
module tb_multicycle_controller;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   multicycle_controller_if #(.CNT_W(32)) bus ();
   multicycle_controller_if #(.CNT_W(32)) bt ();

   multicycle_controller #(.CNT_W(32), .TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   multicycle_controller #(.CNT_W(32), .TIMEOUT(4)) dut_t (
      .clk (clk),
      .rst (rst),
      .bus (bt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [6:0] op, input logic rw, input logic mw, input logic eb,
                         input logic ir, input logic dr, input logic rs);
      bus.in_opcode     = op;
      bus.in_reg_write  = rw;
      bus.in_mem_write  = mw;
      bus.in_ebreak     = eb;
      bus.in_imem_ready = ir;
      bus.in_dmem_ready = dr;
      bus.in_resume     = rs;
      #1;
   endtask

   task automatic set_t(input logic [6:0] op, input logic rw, input logic mw,
                        input logic ir, input logic dr);
      bt.in_opcode     = op;
      bt.in_reg_write  = rw;
      bt.in_mem_write  = mw;
      bt.in_ebreak     = 1'b0;
      bt.in_imem_ready = ir;
      bt.in_dmem_ready = dr;
      bt.in_resume     = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      set_in(7'h00, 0, 0, 0, 0, 0, 0);
      set_t(7'h00, 0, 0, 0, 0);
      check_eq("rst_state", 32'(bus.out_state), 0);
      check_eq("rst_imem_req", 32'(bus.out_imem_req), 1);
      check_eq("rst_dmem_req", 32'(bus.out_dmem_req), 0);
      check_eq("rst_pc_write", 32'(bus.out_pc_write), 0);
      check_eq("rst_instret", bus.out_instret, 0);
      check_eq("rst_cycles", bus.out_cycles, 0);
      tick();
      tick();
      rst = 1'b0;

      // ADD
      set_in(7'b0110011, 1, 0, 0, 1, 0, 0);
      check_eq("add_s0", 32'(bus.out_state), 0);
      check_eq("add_ir_write", 32'(bus.out_ir_write), 1);
      check_eq("add_rf_f", 32'(bus.out_rf_write), 0);
      tick();
      check_eq("add_s1", 32'(bus.out_state), 1);
      check_eq("add_pc_d", 32'(bus.out_pc_write), 0);
      tick();
      check_eq("add_s2", 32'(bus.out_state), 2);
      check_eq("add_rf_e", 32'(bus.out_rf_write), 0);
      tick();
      check_eq("add_s4", 32'(bus.out_state), 4);
      check_eq("add_rf_wb", 32'(bus.out_rf_write), 1);
      check_eq("add_pc_wb", 32'(bus.out_pc_write), 1);
      tick();
      check_eq("add_back", 32'(bus.out_state), 0);
      check_eq("add_instret", bus.out_instret, 1);
      check_eq("add_cycles", bus.out_cycles, 4);

      // LW with three MEM cycles
      set_in(7'b0000011, 1, 0, 0, 1, 0, 0);
      tick();
      check_eq("lw_s1", 32'(bus.out_state), 1);
      tick();
      check_eq("lw_s2", 32'(bus.out_state), 2);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(7'b0000011, 1, 0, 0, 1, (i == 2), 0);
         check_eq("lw_mem", 32'(bus.out_state), 3);
         check_eq("lw_dmem_req", 32'(bus.out_dmem_req), 1);
         check_eq("lw_dmem_we", 32'(bus.out_dmem_we), 0);
         check_eq("lw_pc_mem", 32'(bus.out_pc_write), 0);
         tick();
      end
      check_eq("lw_s4", 32'(bus.out_state), 4);
      check_eq("lw_rf_wb", 32'(bus.out_rf_write), 1);
      tick();
      check_eq("lw_back", 32'(bus.out_state), 0);
      check_eq("lw_instret", bus.out_instret, 2);
      check_eq("lw_cycles", bus.out_cycles, 11);

      // SW with ready in the first MEM cycle
      set_in(7'b0100011, 0, 1, 0, 1, 1, 0);
      tick();
      tick();
      tick();
      check_eq("sw_s3", 32'(bus.out_state), 3);
      check_eq("sw_dmem_we", 32'(bus.out_dmem_we), 1);
      check_eq("sw_pc", 32'(bus.out_pc_write), 1);
      check_eq("sw_rf", 32'(bus.out_rf_write), 0);
      tick();
      check_eq("sw_back", 32'(bus.out_state), 0);
      check_eq("sw_instret", bus.out_instret, 3);
      check_eq("sw_cycles", bus.out_cycles, 15);

      // EBREAK halts until resume; stray ready inputs are ignored
      set_in(7'b1110011, 0, 0, 1, 1, 1, 0);
      tick();
      tick();
      for (int i = 0; i < 10; i++) tick();
      check_eq("eb_state", 32'(bus.out_state), 5);
      check_eq("eb_halted", 32'(bus.out_halted), 1);
      check_eq("eb_cycles", bus.out_cycles, 17);
      check_eq("eb_pc_idle", 32'(bus.out_pc_write), 0);
      check_eq("eb_imem_req", 32'(bus.out_imem_req), 0);
      set_in(7'b1110011, 0, 0, 1, 1, 1, 1);
      check_eq("eb_pc_resume", 32'(bus.out_pc_write), 1);
      tick();
      set_in(7'b0000000, 0, 0, 0, 0, 0, 0);
      check_eq("eb_back", 32'(bus.out_state), 0);
      check_eq("eb_instret", bus.out_instret, 4);
      check_eq("eb_halted_clr", 32'(bus.out_halted), 0);

      // resume outside HALT is ignored
      set_in(7'b0000000, 0, 0, 0, 0, 0, 1);
      tick();
      check_eq("resume_ign", 32'(bus.out_state), 0);
      check_eq("resume_ign_ir", bus.out_instret, 4);

      // reset while a store waits in MEM
      set_in(7'b0100011, 0, 1, 0, 1, 0, 0);
      tick();
      tick();
      tick();
      check_eq("rm_mem", 32'(bus.out_state), 3);
      rst = 1'b1;
      #1;
      check_eq("rm_state", 32'(bus.out_state), 0);
      check_eq("rm_dmem_req", 32'(bus.out_dmem_req), 0);
      check_eq("rm_instret", bus.out_instret, 0);
      check_eq("rm_cycles", bus.out_cycles, 0);
      tick();
      rst = 1'b0;

      // illegal opcode is a sticky fault
      set_in(7'b1111111, 0, 0, 0, 1, 0, 0);
      tick();
      tick();
      check_eq("ill_state", 32'(bus.out_state), 6);
      check_eq("ill_code", 32'(bus.out_fault_code), 1);
      check_eq("ill_fault", 32'(bus.out_fault), 1);
      set_in(7'b0110011, 1, 0, 0, 1, 1, 1);
      tick();
      tick();
      tick();
      check_eq("ill_sticky", 32'(bus.out_state), 6);
      check_eq("ill_code_hold", 32'(bus.out_fault_code), 1);
      check_eq("ill_imem_req", 32'(bus.out_imem_req), 0);
      check_eq("ill_cycles", bus.out_cycles, 2);

      // TIMEOUT=4: ready on the fourth FETCH cycle wins
      do_reset();
      set_t(7'b0110011, 1, 0, 0, 0);
      tick();
      tick();
      tick();
      check_eq("to_wait", 32'(bt.out_state), 0);
      set_t(7'b0110011, 1, 0, 1, 0);
      tick();
      check_eq("to_ready_win", 32'(bt.out_state), 1);
      tick();
      tick();
      tick();
      check_eq("to_add_done", 32'(bt.out_state), 0);
      check_eq("to_add_ir", bt.out_instret, 1);

      // TIMEOUT=4: imem never ready
      set_t(7'b0110011, 1, 0, 0, 0);
      tick();
      tick();
      tick();
      check_eq("to_f_pre", 32'(bt.out_state), 0);
      tick();
      check_eq("to_f_state", 32'(bt.out_state), 6);
      check_eq("to_f_code", 32'(bt.out_fault_code), 2);

      // TIMEOUT=4: dmem never ready on a load
      do_reset();
      set_t(7'b0000011, 1, 0, 1, 0);
      tick();
      tick();
      tick();
      check_eq("to_m_mem", 32'(bt.out_state), 3);
      tick();
      tick();
      tick();
      check_eq("to_m_pre", 32'(bt.out_state), 3);
      tick();
      check_eq("to_m_state", 32'(bt.out_state), 6);
      check_eq("to_m_code", 32'(bt.out_fault_code), 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
